lookup3_seq: RTL and testbench

LOOKUP3_SEQ -- requirements
Module: lookup3_seq

---
 rtl/lookup3_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_lookup3_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup3_seq.sv
// Sequential lookup3 (Jenkins) hash engine: key words streamed over a valid/ready port, one mix/final sub-step per cycle.
// Optional protocol error flag enabled by defining LOOKUP3_SEQ_ERR_EN; otherwise err is tied low.
module lookup3_seq (
   input  logic        clk,
   input  logic        res,
   input  logic        start,
   input  logic [31:0] len,
   input  logic [31:0] initval,
   input  logic        kw_valid,
   input  logic [31:0] kw_data,
   output logic        kw_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] hash,
   output logic        err
);

   // Handshake: a key word transfers on a rising clk edge where kw_valid && kw_ready;
   // kw_ready depends on state only, and kw_valid while kw_ready is low is discarded.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MIX   = 3'd2,
      TAIL  = 3'd3,
      FINAL = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t      state;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] c;
   logic [31:0] rem;
   logic [1:0]  idx;
   logic [2:0]  step;

   logic [31:0] seed;
   logic [31:0] mix_a;
   logic [31:0] mix_b;
   logic [31:0] mix_c;
   logic [31:0] fin_a;
   logic [31:0] fin_b;
   logic [31:0] fin_c;
   logic        tail_last;
   logic [31:0] word_m;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
      return (x << k) | (x >> (32 - k));
   endfunction

   assign seed     = 32'hDEADBEEF + len + initval;
   assign kw_ready = (state == LOAD) || (state == TAIL);
   assign busy     = (state != IDLE);

   // The current tail word is the last one once its byte span reaches rem.
   assign tail_last = (({28'd0, idx, 2'b00} + 32'd4) >= rem);

   always_comb begin
      word_m = kw_data;
      if (tail_last) begin
         case (rem[1:0])
            2'd1:    word_m = kw_data & 32'hFF000000;
            2'd2:    word_m = kw_data & 32'hFFFF0000;
            2'd3:    word_m = kw_data & 32'hFFFFFF00;
            default: word_m = kw_data;
         endcase
      end
   end

   always_comb begin
      mix_a = a;
      mix_b = b;
      mix_c = c;
      case (step)
         3'd0: begin mix_a = (a - c) ^ rotl(c, 4);  mix_c = c + b; end
         3'd1: begin mix_b = (b - a) ^ rotl(a, 6);  mix_a = a + c; end
         3'd2: begin mix_c = (c - b) ^ rotl(b, 8);  mix_b = b + a; end
         3'd3: begin mix_a = (a - c) ^ rotl(c, 16); mix_c = c + b; end
         3'd4: begin mix_b = (b - a) ^ rotl(a, 19); mix_a = a + c; end
         3'd5: begin mix_c = (c - b) ^ rotl(b, 4);  mix_b = b + a; end
         default: begin
            mix_a = a;
            mix_b = b;
            mix_c = c;
         end
      endcase
   end

   always_comb begin
      fin_a = a;
      fin_b = b;
      fin_c = c;
      case (step)
         3'd0: fin_c = (c ^ b) - rotl(b, 14);
         3'd1: fin_a = (a ^ c) - rotl(c, 11);
         3'd2: fin_b = (b ^ a) - rotl(a, 25);
         3'd3: fin_c = (c ^ b) - rotl(b, 16);
         3'd4: fin_a = (a ^ c) - rotl(c, 4);
         3'd5: fin_b = (b ^ a) - rotl(a, 14);
         3'd6: fin_c = (c ^ b) - rotl(b, 24);
         default: begin
            fin_a = a;
            fin_b = b;
            fin_c = c;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state <= IDLE;
         a     <= 32'd0;
         b     <= 32'd0;
         c     <= 32'd0;
         rem   <= 32'd0;
         idx   <= 2'd0;
         step  <= 3'd0;
         done  <= 1'b0;
         hash  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a    <= seed;
                  b    <= seed;
                  c    <= seed;
                  rem  <= len;
                  idx  <= 2'd0;
                  step <= 3'd0;
                  if (len == 32'd0) begin
                     hash  <= seed;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (len > 32'd12) begin
                     state <= LOAD;
                  end else begin
                     state <= TAIL;
                  end
               end
            end
            LOAD: begin
               if (kw_valid) begin
                  case (idx)
                     2'd0: begin a <= a + kw_data; idx <= 2'd1; end
                     2'd1: begin b <= b + kw_data; idx <= 2'd2; end
                     2'd2: begin
                        c     <= c + kw_data;
                        idx   <= 2'd0;
                        rem   <= rem - 32'd12;
                        step  <= 3'd0;
                        state <= MIX;
                     end
                     default: idx <= 2'd0;
                  endcase
               end
            end
            MIX: begin
               a <= mix_a;
               b <= mix_b;
               c <= mix_c;
               if (step == 3'd5) begin
                  step  <= 3'd0;
                  state <= (rem > 32'd12) ? LOAD : TAIL;
               end else begin
                  step <= step + 3'd1;
               end
            end
            TAIL: begin
               if (kw_valid) begin
                  case (idx)
                     2'd0:    a <= a + word_m;
                     2'd1:    b <= b + word_m;
                     default: c <= c + word_m;
                  endcase
                  if (tail_last) begin
                     idx   <= 2'd0;
                     step  <= 3'd0;
                     state <= FINAL;
                  end else begin
                     idx <= idx + 2'd1;
                  end
               end
            end
            FINAL: begin
               a <= fin_a;
               b <= fin_b;
               c <= fin_c;
               if (step == 3'd6) begin
                  step  <= 3'd0;
                  hash  <= fin_c;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  step <= step + 3'd1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef LOOKUP3_SEQ_ERR_EN
   // Sticky until reset or the next accepted job.
   always_ff @(posedge clk) begin
      if (res) begin
         err <= 1'b0;
      end else if ((state == IDLE) && start) begin
         err <= 1'b0;
      end else if ((start && (state != IDLE)) ||
                   (kw_valid && ((state == MIX) || (state == FINAL) || (state == DONE)))) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lookup3_seq.sv
// Self-checking bench for lookup3_seq: randomized jobs against a lookup3 reference model,
// plus directed reset, zero-length, stall/mask, mid-job reset and protocol-error scenarios.
module tb_lookup3_seq;

   logic        clk;
   logic        res;
   logic        start;
   logic [31:0] len;
   logic [31:0] initval;
   logic        kw_valid;
   logic [31:0] kw_data;
   logic        kw_ready;
   logic        busy;
   logic        done;
   logic [31:0] hash;
   logic        err;

   int          n_vec;
   int          n_err;
   logic [31:0] exp_q[$];
   logic [31:0] key_w [0:15];

`ifdef LOOKUP3_SEQ_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   lookup3_seq dut (
      .clk      (clk),
      .res      (res),
      .start    (start),
      .len      (len),
      .initval  (initval),
      .kw_valid (kw_valid),
      .kw_data  (kw_data),
      .kw_ready (kw_ready),
      .busy     (busy),
      .done     (done),
      .hash     (hash),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rot(input logic [31:0] x, input int k);
      return (x << k) | (x >> (32 - k));
   endfunction

   // Reference lookup3 over key_w: 12-byte blocks with mix, masked tail, final.
   function automatic logic [31:0] model_hash(input int unsigned klen, input logic [31:0] iv);
      logic [31:0] ma, mb, mc, w;
      int unsigned rm;
      int k;
      ma = 32'hDEADBEEF + klen + iv;
      mb = ma;
      mc = ma;
      rm = klen;
      k  = 0;
      if (klen == 0) return mc;
      while (rm > 12) begin
         ma += key_w[k]; mb += key_w[k+1]; mc += key_w[k+2];
         ma -= mc; ma ^= rot(mc, 4);  mc += mb;
         mb -= ma; mb ^= rot(ma, 6);  ma += mc;
         mc -= mb; mc ^= rot(mb, 8);  mb += ma;
         ma -= mc; ma ^= rot(mc, 16); mc += mb;
         mb -= ma; mb ^= rot(ma, 19); ma += mc;
         mc -= mb; mc ^= rot(mb, 4);  mb += ma;
         rm -= 12;
         k  += 3;
      end
      for (int j = 0; j < 3; j++) begin
         if (rm > 4 * j) begin
            w = key_w[k+j];
            if (rm - 4 * j < 4) w = w & ~(32'hFFFFFFFF >> (8 * (rm - 4 * j)));
            if (j == 0) ma += w;
            else if (j == 1) mb += w;
            else mc += w;
         end
      end
      mc ^= mb; mc -= rot(mb, 14);
      ma ^= mc; ma -= rot(mc, 11);
      mb ^= ma; mb -= rot(ma, 25);
      mc ^= mb; mc -= rot(mb, 16);
      ma ^= mc; ma -= rot(mc, 4);
      mb ^= ma; mb -= rot(ma, 14);
      mc ^= mb; mc -= rot(mb, 24);
      return mc;
   endfunction

   function automatic int blocks_of(input int unsigned klen);
      return (klen > 12) ? int'((klen - 1) / 12) : 0;
   endfunction

   function automatic int exp_words(input int unsigned klen);
      int nb;
      nb = blocks_of(klen);
      return nb * 3 + int'((klen - 12 * nb + 3) / 4);
   endfunction

   // Unstalled cycles from accepted start to done: 3 loads + 6 mix per block, tail words, 7 final, 1 done.
   function automatic int exp_latency(input int unsigned klen);
      int nb;
      if (klen == 0) return 1;
      nb = blocks_of(klen);
      return nb * 9 + int'((klen - 12 * nb + 3) / 4) + 8;
   endfunction

   task automatic run_job(input int unsigned jlen, input logic [31:0] iv, input int stall_word,
                          input int stall_cycles, input bit rand_stall, input bit junk_valid,
                          input int busy_start_at, input bit exp_err);
      int lat_exp, words_exp, stalls, stall_left, idx, n_done;
      bit hs, ready_seen;
      logic [31:0] exp_h;
      lat_exp    = exp_latency(jlen);
      words_exp  = exp_words(jlen);
      exp_q.push_back(model_hash(jlen, iv));
      stalls     = 0;
      stall_left = stall_cycles;
      idx        = 0;
      n_done     = 0;
      ready_seen = 1'b0;
      start      = 1'b1;
      len        = jlen;
      initval    = iv;
      kw_valid   = 1'b0;
      @(posedge clk); #1;
      start   = 1'b0;
      len     = $urandom;
      initval = $urandom;
      for (int n = 1; n <= 200 && n_done == 0; n++) begin
         if (n == 1) begin
            n_vec++;
            if (err !== 1'b0) begin
               n_err++;
               $display("FAIL err_clear_on_start len=%0d: got %b expected 0", jlen, err);
            end
         end
         if (done === 1'b1) begin
            n_done = n;
         end else begin
            n_vec++;
            if (busy !== 1'b1) begin
               n_err++;
               $display("FAIL busy_in_job len=%0d cycle=%0d: got %b expected 1", jlen, n, busy);
            end
            start = (n == busy_start_at);
            if (kw_ready === 1'b1) begin
               ready_seen = 1'b1;
               if (idx == stall_word && stall_left > 0) begin
                  kw_valid = 1'b0;
                  stall_left--;
               end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                  kw_valid = 1'b0;
               end else begin
                  kw_valid = 1'b1;
               end
               if (!kw_valid) stalls++;
               kw_data = (idx < 16) ? key_w[idx] : $urandom;
            end else begin
               kw_valid = junk_valid;
               kw_data  = $urandom;
            end
            hs = kw_valid && (kw_ready === 1'b1);
            @(posedge clk); #1;
            if (hs) idx++;
         end
      end
      start    = 1'b0;
      kw_valid = 1'b0;
      exp_h    = exp_q.pop_front();
      n_vec++;
      if (n_done == 0) begin
         n_err++;
         $display("FAIL done_timeout len=%0d: got no done expected done within 200 cycles", jlen);
      end else begin
         n_vec++;
         if (n_done != lat_exp + stalls) begin
            n_err++;
            $display("FAIL latency len=%0d: got %0d expected %0d", jlen, n_done, lat_exp + stalls);
         end
         n_vec++;
         if (hash !== exp_h) begin
            n_err++;
            $display("FAIL hash len=%0d: got %h expected %h", jlen, hash, exp_h);
         end
         n_vec++;
         if (idx != words_exp) begin
            n_err++;
            $display("FAIL words_taken len=%0d: got %0d expected %0d", jlen, idx, words_exp);
         end
         n_vec++;
         if (err !== exp_err) begin
            n_err++;
            $display("FAIL err_at_done len=%0d: got %b expected %b", jlen, err, exp_err);
         end
         if (jlen == 0) begin
            n_vec++;
            if (ready_seen) begin
               n_err++;
               $display("FAIL kw_ready_len0: got 1 expected 0");
            end
         end
         @(posedge clk); #1;
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0 || hash !== exp_h || err !== exp_err) begin
            n_err++;
            $display("FAIL after_done len=%0d: got done=%b busy=%b hash=%h err=%b expected 0 0 %h %b",
                     jlen, done, busy, hash, err, exp_h, exp_err);
         end
      end
   endtask

   task automatic test_reset();
      res      = 1'b1;
      start    = 1'b1;
      len      = 32'd20;
      initval  = $urandom;
      kw_valid = 1'b1;
      kw_data  = $urandom;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || kw_ready !== 1'b0 || hash !== 32'd0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got busy=%b done=%b kw_ready=%b hash=%h err=%b expected all 0",
                  busy, done, kw_ready, hash, err);
      end
      res      = 1'b0;
      start    = 1'b0;
      kw_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_len_zero();
      run_job(0, 32'h0, -1, 0, 1'b0, 1'b0, 0, 1'b0);
      n_vec++;
      if (hash !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL len0_seed0: got %h expected deadbeef", hash);
      end
      run_job(0, 32'hDEADBEEF, -1, 0, 1'b0, 1'b0, 0, 1'b0);
      n_vec++;
      if (hash !== 32'hBD5B7DDE) begin
         n_err++;
         $display("FAIL len0_seed_deadbeef: got %h expected bd5b7dde", hash);
      end
   endtask

   task automatic test_back_to_back();
      key_w[0] = 32'h61626364;
      key_w[1] = 32'h65666768;
      key_w[2] = 32'h696A6B6C;
      run_job(12, 32'h0, -1, 0, 1'b0, 1'b0, 0, 1'b0);
      key_w[0] = $urandom;
      run_job(12, $urandom, -1, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_stall_mask();
      key_w[0] = 32'h61626364;
      key_w[1] = 32'h65666768;
      key_w[2] = 32'h696A6B6C;
      key_w[3] = 32'h6DFFFFFF;
      run_job(13, 32'h0, 3, 2, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_job();
      int idx, done_hits;
      bit hs;
      for (int j = 0; j < 16; j++) key_w[j] = $urandom;
      idx     = 0;
      start   = 1'b1;
      len     = 32'd24;
      initval = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         kw_valid = (kw_ready === 1'b1);
         kw_data  = key_w[idx];
         hs       = kw_valid;
         @(posedge clk); #1;
         if (hs) idx++;
      end
      kw_valid = 1'b0;
      res      = 1'b1;
      @(posedge clk); #1;
      res = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || kw_ready !== 1'b0 || hash !== 32'd0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL midjob_reset_state: got busy=%b done=%b kw_ready=%b hash=%h err=%b expected all 0",
                  busy, done, kw_ready, hash, err);
      end
      done_hits = 0;
      for (int n = 0; n < 30; n++) begin
         if (done === 1'b1) done_hits++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (done_hits != 0) begin
         n_err++;
         $display("FAIL abandoned_job_done: got %0d done pulses expected 0", done_hits);
      end
      key_w[0] = 32'h00000001;
      run_job(4, $urandom, -1, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_start_busy();
      for (int j = 0; j < 16; j++) key_w[j] = $urandom;
      run_job(12, $urandom, -1, 0, 1'b0, 1'b0, 6, ERR_EN);
      run_job(12, $urandom, -1, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_ignore_kw();
      for (int j = 0; j < 16; j++) key_w[j] = $urandom;
      kw_valid = 1'b1;
      repeat (3) begin
         kw_data = $urandom;
         @(posedge clk); #1;
      end
      n_vec++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_kw_valid: got err=%b busy=%b expected 0 0", err, busy);
      end
      kw_valid = 1'b0;
      run_job(24, $urandom, -1, 0, 1'b1, 1'b1, 0, ERR_EN);
   endtask

   task automatic test_random();
      int unsigned lens [0:11];
      lens = '{1, 2, 3, 4, 5, 11, 12, 13, 24, 25, 36, 37};
      for (int i = 0; i < 12; i++) begin
         for (int j = 0; j < 16; j++) key_w[j] = $urandom;
         run_job(lens[i], $urandom, -1, 0, 1'b1, 1'b0, 0, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) key_w[j] = $urandom;
         run_job($urandom_range(0, 48), $urandom, -1, 0, 1'b1, 1'b0, 0, 1'b0);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      res      = 1'b1;
      start    = 1'b0;
      len      = 32'd0;
      initval  = 32'd0;
      kw_valid = 1'b0;
      kw_data  = 32'd0;
      for (int j = 0; j < 16; j++) key_w[j] = 32'd0;
      @(posedge clk); #1;
      test_reset();
      test_len_zero();
      test_back_to_back();
      test_stall_mask();
      test_reset_mid_job();
      test_start_busy();
      test_ignore_kw();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
